// File: rtl/exec_controller.sv
// Execution controller for the single-cycle RV32 core: stop, single-step
// and divided free-run modes with breakpoint / EBREAK / illegal halts.
module exec_controller #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int RUN_DIV         = 25000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        step_btn,
    input  logic        run_sw,
    input  logic        bp_en,
    input  logic [31:0] bp_addr,
    input  logic [31:0] pc,
    input  logic [31:0] instruction,
    output logic        cpu_en,
    output logic [1:0]  state,
    output logic [1:0]  halt_cause,
    output logic [31:0] retired
);

    localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int DVW = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
    localparam logic [DBW-1:0] DB_LAST  = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DVW-1:0] DIV_LAST = DVW'(RUN_DIV - 1);
    localparam logic [31:0]    EBREAK   = 32'h0010_0073;

    typedef enum logic [1:0] {
        ST_STOP  = 2'b00,
        ST_STEP  = 2'b01,
        ST_RUN   = 2'b10,
        ST_BREAK = 2'b11
    } state_t;

    state_t         st;
    logic           btn_s1, btn_s2;
    logic           run_s1, run_s2;
    logic [DBW-1:0] db_cnt;
    logic           db_level;
    logic           db_prev;
    logic           step_req;
    logic [DVW-1:0] div;
    logic           skip;
    logic           tick;
    logic           hit;
    logic [1:0]     cause;

    assign state = st;

    // Two-flop synchronizers for the raw board inputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_s1 <= 1'b0;
            btn_s2 <= 1'b0;
            run_s1 <= 1'b0;
            run_s2 <= 1'b0;
        end else begin
            btn_s1 <= step_btn;
            btn_s2 <= btn_s1;
            run_s1 <= run_sw;
            run_s2 <= run_s1;
        end
    end

    // Debounce: accept a new button level only after it has persisted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_cnt   <= '0;
            db_level <= 1'b0;
        end else if (btn_s2 == db_level) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            db_level <= btn_s2;
            db_cnt   <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    // One-cycle step request on the debounced press edge only
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_prev  <= 1'b0;
            step_req <= 1'b0;
        end else begin
            db_prev  <= db_level;
            step_req <= db_level & ~db_prev;
        end
    end

    // Halt classification of the instruction currently at the PC
    always_comb begin
        cause = 2'b00;
        if (bp_en && (pc == bp_addr)) begin
            cause = 2'b01;
        end else if (instruction == EBREAK) begin
            cause = 2'b10;
        end else if (instruction == 32'h0) begin
            cause = 2'b11;
        end
    end

    assign tick   = (div == DIV_LAST);
    assign hit    = (cause != 2'b00);
    assign cpu_en = (st == ST_STEP) ||
                    ((st == ST_RUN) && run_s2 && tick && (skip || !hit));

    // Mode FSM with run divider, resume-skip flag and latched halt cause
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st         <= ST_STOP;
            div        <= '0;
            skip       <= 1'b0;
            halt_cause <= 2'b00;
        end else begin
            if (cpu_en) begin
                halt_cause <= 2'b00;
            end
            unique case (st)
                ST_STOP: begin
                    if (run_s2) begin
                        st   <= ST_RUN;
                        skip <= 1'b1;
                        div  <= '0;
                    end else if (step_req) begin
                        st <= ST_STEP;
                    end
                end
                ST_STEP: begin
                    st <= ST_STOP;
                end
                ST_RUN: begin
                    if (!run_s2) begin
                        st  <= ST_STOP;
                        div <= '0;
                    end else if (tick) begin
                        div <= '0;
                        if (skip) begin
                            skip <= 1'b0;
                        end else if (hit) begin
                            st         <= ST_BREAK;
                            halt_cause <= cause;
                        end
                    end else begin
                        div <= div + 1'b1;
                    end
                end
                ST_BREAK: begin
                    if (!run_s2) begin
                        st <= ST_STOP;
                    end
                end
            endcase
        end
    end

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired <= '0;
        end else if (cpu_en) begin
            retired <= retired + 32'd1;
        end
    end

endmodule

// File: doc/exec_controller.md
# exec_controller

Execution controller for the single-cycle RV32 core. It produces the core-wide clock enable `cpu_en`, which gates the PC, register-file and data-memory writes. Supported modes are stopped, single-step from a board button, and free-run at a divided rate. In run mode it halts on a PC breakpoint, on EBREAK, or on an all-zero instruction word, and it counts retired instructions for the 7-segment/VGA debug views.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required to accept a `step_btn` level change; minimum 1.
- `RUN_DIV`, default 25000000: in RUN, one `cpu_en` pulse every `RUN_DIV` cycles; minimum 1 (1 = every cycle).
- `clk` in 1: system clock; all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `step_btn` in 1: raw, asynchronous step pushbutton, active-high.
- `run_sw` in 1: raw, asynchronous run switch, 1 = run.
- `bp_en` in 1: breakpoint enable, quasi-static.
- `bp_addr` in 32: breakpoint PC, quasi-static.
- `pc` in 32: current PC from the PC register.
- `instruction` in 32: current instruction-memory output.
- `cpu_en` out 1: core write/advance enable; one retired instruction per high cycle.
- `state` out 2: 00 STOP, 01 STEP, 10 RUN, 11 BREAK.
- `halt_cause` out 2: 00 none, 01 breakpoint, 10 EBREAK (0x00100073), 11 illegal (0x00000000).
- `retired` out 32: count of `cpu_en` high cycles; wraps modulo 2^32.

## Operation
- Reset (async, takes effect immediately): state STOP, `cpu_en`=0, `halt_cause`=00, `retired`=0, divider=0, all sync/debounce flops=0, skip flag=0.
- Input conditioning:
  - `step_btn` and `run_sw` each pass through a 2-flop synchronizer.
  - Debounce for `step_btn`: the debounced level flips after the synced value has differed from it for `DEBOUNCE_CYCLES` consecutive cycles. Any agreement clears the counter.
  - `step_req` is a one-cycle registered pulse on the debounced rising edge. Falling edges are ignored.
- STOP: synced `run_sw`=1 → RUN, which sets the skip flag and clears the divider. Otherwise `step_req` → STEP. `run_sw` has priority; a simultaneous `step_req` is dropped.
- STEP: `cpu_en`=1 for exactly this one cycle, then → STOP. No halt checks are applied.
- RUN:
  - The divider counts 0..`RUN_DIV`-1 and wraps. A tick occurs when divider = `RUN_DIV`-1.
  - On a tick, evaluate the halt check unless the skip flag is set.
  - Halt check priority: `bp_en` && `pc`==`bp_addr` → 01; else `instruction`==0x00100073 → 10; else `instruction`==0 → 11.
  - Hit: `cpu_en` stays 0, next state BREAK, `halt_cause` latched.
  - No hit (or skip): `cpu_en`=1; the skip flag clears on the first tick.
  - Synced `run_sw`=0 → STOP with divider cleared; the check takes priority over a tick in the same cycle.
- BREAK:
  - `cpu_en`=0.
  - Synced `run_sw`=0 → STOP. `halt_cause` holds.
  - `step_req` while `run_sw`=1 is ignored.
  - Leaving to RUN requires passing through STOP, which sets skip so the halting instruction executes.
- `halt_cause` clears to 00 on any cycle with `cpu_en`=1.
- `retired` increments by 1 on every `cpu_en`=1 cycle.

## Timing
- `cpu_en` is combinational from the registered state/divider/skip and the `pc`/`instruction` compare. It is stable before the core's sampling edge.
- Step latency: a `step_btn` rising edge that meets setup before edge 1 yields `cpu_en` high during the cycle after edge `DEBOUNCE_CYCLES`+4 (edge 2 sync, edge 2+D debounced, edge 3+D `step_req`, edge 4+D STEP).
- `run_sw` latency: STOP→RUN is visible 3 edges after the switch change. The first `cpu_en` follows `RUN_DIV` cycles later.
- Halt: the hit is detected in the tick cycle. `state`=11 and `halt_cause` are valid after the next edge. The halting instruction does not retire.
- A held button produces exactly one step. A new step needs release (debounced low) then press.
- Reset mid-RUN or mid-STEP: `cpu_en` drops in the same cycle and no partial retire is counted.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `RUN_DIV`=3; the core model advances `pc` by 4 per `cpu_en`.

- Reset: assert `rst` while in RUN with `cpu_en` high → `cpu_en`=0 the same cycle; `state`=00, `retired`=0, `halt_cause`=00.
- Step:
  - `step_btn` high for 10 cycles → exactly one `cpu_en` cycle, in the cycle after edge 8; `retired`=1; `state` returns to 00.
  - A 2-cycle glitch → no `cpu_en`.
- Run: `run_sw`=1, `instruction`=0x00000013, `bp_en`=0, for 30 cycles after entry → `cpu_en` every 3rd cycle, `retired`=10, `state`=10.
- Breakpoint:
  - `bp_en`=1, `bp_addr`=0x10, run from `pc`=0 → halt with `pc`=0x10, `state`=11, `halt_cause`=01, `retired`=4.
  - Toggle `run_sw` 0→1 → the first tick retires `pc` 0x10 (skip), `halt_cause`=00, `retired`=5.
- EBREAK and illegal:
  - `instruction`=0x00100073 in RUN → BREAK with cause 10.
  - `instruction`=0 with `run_sw`=0 then a step → one `cpu_en`; cause 11 is never raised in STEP.
- Simultaneous events: `run_sw` sync rise in the same cycle as `step_req` in STOP → RUN entered, no STEP cycle. `run_sw` falling on a tick cycle → no `cpu_en`, `state`=00.
